// File: rtl/mode_online_multi.sv
// Online-control mode for NUM_CH traffic lights: accepts remote commands via valid/ready
// and sequences GREEN->YELLOW->all-RED->GREEN with at most one non-RED channel at a time.
module mode_online_multi #(
    parameter int NUM_CH       = 4,
    parameter int CH_W         = 3,
    parameter int CLK_PER_SEC  = 100000000,
    parameter int TIME_W       = 5,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enb,
    input  logic                  online,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CH_W-1:0]       cmd_ch,
    input  logic [1:0]            cmd_light,
    input  logic [2*NUM_CH-1:0]   last_state,
    output logic [2*NUM_CH-1:0]   light,
    output logic [TIME_W-1:0]     light_time,
    output logic                  feedback,
    output logic                  busy,
    output logic                  cmd_err
);

    localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0]     PMAX   = PW'(CLK_PER_SEC - 1);
    localparam logic [TIME_W-1:0] T_YEL  = TIME_W'(YELLOW_TIME);
    localparam logic [TIME_W-1:0] T_ARED = TIME_W'(ALL_RED_TIME);
    localparam logic [1:0] L_RED = 2'b00;
    localparam logic [1:0] L_YEL = 2'b01;
    localparam logic [1:0] L_GRN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_YEL    = 2'd1,
        ST_ALLRED = 2'd2
    } state_t;

    state_t                r_state;
    logic [2*NUM_CH-1:0]   r_buf;
    logic [2*NUM_CH-1:0]   r_light;
    logic                  r_act_vld;
    logic [CH_W-1:0]       r_act_ch;
    logic                  r_pend_vld;
    logic [CH_W-1:0]       r_pend_ch;
    logic [PW-1:0]         r_presc;
    logic [TIME_W-1:0]     r_time;
    logic                  r_feedback;
    logic                  r_cmd_err;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_ch_ok;
    logic                  w_invalid;
    logic                  w_wrap;
    logic                  w_last_sec;
    logic [2*NUM_CH-1:0]   w_buf_cleared;
    logic [2*NUM_CH-1:0]   w_buf_applied;

    function automatic logic [2*NUM_CH-1:0] set_ch(input logic [2*NUM_CH-1:0] b,
                                                   input logic [CH_W-1:0] ch,
                                                   input logic [1:0] v);
        logic [2*NUM_CH-1:0] r;
        r = b;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch == CH_W'(i)) r[2*i +: 2] = v;
        end
        return r;
    endfunction

    // rst_n gates ready so nothing is offered while the block is held in reset
    assign w_ready    = rst_n & enb & online & (r_state == ST_IDLE);
    assign w_accept   = cmd_valid & w_ready;
    assign w_ch_ok    = ({1'b0, cmd_ch} < (CH_W+1)'(NUM_CH));
    assign w_invalid  = ~w_ch_ok | (cmd_light == L_YEL) | (cmd_light == 2'b11);
    assign w_wrap     = (r_presc == PMAX);
    assign w_last_sec = (r_time <= TIME_W'(1));

    // Yellow exit clears the active channel; pending green lands on top of that
    assign w_buf_cleared = set_ch(r_buf, r_act_ch, L_RED);
    assign w_buf_applied = r_pend_vld ? set_ch(w_buf_cleared, r_pend_ch, L_GRN) : w_buf_cleared;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_buf      <= '0;
            r_light    <= '0;
            r_act_vld  <= 1'b0;
            r_act_ch   <= '0;
            r_pend_vld <= 1'b0;
            r_pend_ch  <= '0;
            r_presc    <= '0;
            r_time     <= '0;
            r_feedback <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_feedback <= enb;
            r_light    <= enb ? r_buf : last_state;
            r_cmd_err  <= w_accept & w_invalid;

            if (!enb && r_state != ST_IDLE) begin
                r_state    <= ST_IDLE;
                r_buf      <= '0;
                r_act_vld  <= 1'b0;
                r_pend_vld <= 1'b0;
                r_presc    <= '0;
                r_time     <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_presc <= '0;
                        r_time  <= '0;
                        if (w_accept && !w_invalid) begin
                            if (cmd_light == L_GRN) begin
                                if (!r_act_vld) begin
                                    r_buf     <= set_ch(r_buf, cmd_ch, L_GRN);
                                    r_act_vld <= 1'b1;
                                    r_act_ch  <= cmd_ch;
                                end else if (r_act_ch != cmd_ch) begin
                                    r_buf      <= set_ch(r_buf, r_act_ch, L_YEL);
                                    r_pend_vld <= 1'b1;
                                    r_pend_ch  <= cmd_ch;
                                    r_state    <= ST_YEL;
                                    r_time     <= T_YEL;
                                end
                            end else if (r_act_vld && r_act_ch == cmd_ch) begin
                                r_buf      <= set_ch(r_buf, r_act_ch, L_YEL);
                                r_pend_vld <= 1'b0;
                                r_state    <= ST_YEL;
                                r_time     <= T_YEL;
                            end
                        end
                    end
                    ST_YEL: begin
                        if (!w_wrap) begin
                            r_presc <= r_presc + PW'(1);
                        end else begin
                            r_presc <= '0;
                            if (!w_last_sec) begin
                                r_time <= r_time - TIME_W'(1);
                            end else if (ALL_RED_TIME > 0) begin
                                r_buf     <= w_buf_cleared;
                                r_act_vld <= 1'b0;
                                r_state   <= ST_ALLRED;
                                r_time    <= T_ARED;
                            end else begin
                                r_buf      <= w_buf_applied;
                                r_act_vld  <= r_pend_vld;
                                r_act_ch   <= r_pend_ch;
                                r_pend_vld <= 1'b0;
                                r_state    <= ST_IDLE;
                                r_time     <= '0;
                            end
                        end
                    end
                    ST_ALLRED: begin
                        if (!w_wrap) begin
                            r_presc <= r_presc + PW'(1);
                        end else begin
                            r_presc <= '0;
                            if (!w_last_sec) begin
                                r_time <= r_time - TIME_W'(1);
                            end else begin
                                if (r_pend_vld) r_buf <= set_ch(r_buf, r_pend_ch, L_GRN);
                                r_act_vld  <= r_pend_vld;
                                r_act_ch   <= r_pend_ch;
                                r_pend_vld <= 1'b0;
                                r_state    <= ST_IDLE;
                                r_time     <= '0;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_buf   <= '0;
                        r_time  <= '0;
                        r_presc <= '0;
                    end
                endcase
            end
        end
    end

    assign cmd_ready  = w_ready;
    assign light      = r_light;
    assign light_time = r_time;
    assign feedback   = r_feedback;
    assign busy       = (r_state != ST_IDLE);
    assign cmd_err    = r_cmd_err;

endmodule

// File: doc/mode_online_multi.md
Name: mode_online_multi

Overview:
- Parametrised next-generation online-control mode for the traffic light controller; drives NUM_CH lights instead of one.
- Accepts remote (online) light commands through a valid/ready handshake.
- Enforces safe sequencing: GREEN->YELLOW->all-RED->GREEN, and at most one channel non-RED at any time.
- Shows a seconds countdown for timed phases; hands lights back to last_state when the mode is disabled.

Parameters:
- NUM_CH, 4, number of light channels (2..8).
- CH_W, 3, width of cmd_ch; must satisfy 2^CH_W >= NUM_CH.
- CLK_PER_SEC, 100000000, clk cycles per displayed second (bench overrides to 4).
- TIME_W, 5, width of light_time.
- YELLOW_TIME, 3, yellow phase in seconds; >=1 and <2^TIME_W.
- ALL_RED_TIME, 2, all-red clearance in seconds; 0 skips the phase; <2^TIME_W.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- enb  in  1  mode enable; 0 = outputs follow last_state.
- online  in  1  remote link up; gates command acceptance.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_ch  in  CH_W  target channel.
- cmd_light  in  2  requested state: RED=00, YELLOW=01, GREEN=10, UNDEFINED=11.
- last_state  in  2*NUM_CH  lights from the previous mode; channel i is bits [2i+1:2i].
- light  out  2*NUM_CH  driven lights, same packing.
- light_time  out  TIME_W  remaining seconds of the current timed phase; 0 otherwise.
- feedback  out  1  registered enb; 1 = this mode owns the lights.
- busy  out  1  a transition sequence is in progress.
- cmd_err  out  1  one-cycle pulse on an accepted invalid command.

Behaviour:
- Reset (async, rst_n=0): buf all RED, light all RED, light_time=0, feedback=0, cmd_ready=0, cmd_err=0, busy=0, FSM=IDLE, prescaler=0, active=none.
- Internal state: buf (per-channel target lights), active (index of the single non-RED channel, or none), FSM IDLE / YEL / ALLRED.
- cmd_ready = enb & online & (FSM==IDLE); combinational. A command is accepted when cmd_valid & cmd_ready.
- Invalid command (cmd_ch >= NUM_CH, or cmd_light = YELLOW or UNDEFINED): accepted, no state change, cmd_err=1 on the next cycle.
- GREEN to k, k==active: accepted no-op.
- GREEN to k, active==none: buf[k]=GREEN next cycle; FSM stays IDLE.
- GREEN to k, active=j!=k: buf[j]=YELLOW, pending=k, FSM->YEL.
- RED to k, k==active: buf[k]=YELLOW, pending=none, FSM->YEL.
- RED to k, k!=active: accepted no-op.
- YEL lasts exactly YELLOW_TIME*CLK_PER_SEC cycles. On exit: buf[active]=RED, active=none; FSM->ALLRED if ALL_RED_TIME>0, else it applies pending.
- ALLRED lasts exactly ALL_RED_TIME*CLK_PER_SEC cycles.
- Applying pending: buf[pending]=GREEN, active=pending, FSM->IDLE. If pending=none, FSM->IDLE with all RED.
- Prescaler: counts 0..CLK_PER_SEC-1; cleared on entry to YEL or ALLRED, so every phase is whole seconds.
- light_time: loaded with the phase length on phase entry; decrements at each prescaler wrap; 0 in IDLE. It never underflows.
- busy=1 whenever FSM != IDLE.
- Outputs are registered, one-cycle latency: light <= enb ? buf : last_state; feedback <= enb.
- online falling mid-sequence: the sequence runs to completion; only acceptance stops.
- enb falling mid-sequence (FSM != IDLE): abort. buf=all RED, active=none, pending dropped, FSM=IDLE, light_time=0.
- enb falling in IDLE: buf is retained.
- enb rising: light shows buf on the next cycle.
- Invariant: at most one channel of buf is non-RED in every cycle. Assert it in the bench.

Test Plan:
- Reset with NUM_CH=4, CLK_PER_SEC=4, then enb=1, online=1 -> light=all RED (0x00), feedback=1, cmd_ready=1, light_time=0.
- GREEN ch2 from all RED -> buf ch2=GREEN after 1 cycle, light=0x20 after 2 cycles, busy stays 0.
- With ch2 GREEN, GREEN ch0 -> ch2 YELLOW for 12 cycles with light_time 3,2,1; then all RED for 8 cycles with light_time 2,1; then light=0x02. cmd_ready=0 throughout.
- cmd_ch=5, and separately cmd_light=YELLOW -> cmd_err pulses once each; lights unchanged. RED to a RED channel -> no change, no error.
- Drop enb during YEL with last_state=0xAA -> light=0xAA next cycle, feedback=0. Re-raise enb -> light=all RED, busy=0.
- Hold cmd_valid with online=0 -> never accepted. Assert rst_n mid-ALLRED -> all outputs at reset values immediately.
